// File: rtl/acc_bank_pkg.sv
// Shared opcodes, MAC FSM state encoding and sizing helper for the accumulator bank.
package acc_bank_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_MAC  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } mac_state_e;

  // Channel-select width; a single-channel bank still carries a 1-bit select.
  function automatic int sel_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/acc_bank_mac.sv
// Sequential shift-and-add multiply-accumulate engine: one multiplier bit per cycle.
// state   | meaning
// IDLE    | waiting for start, operands latched on start
// BUSY    | WIDTH iterations of conditional add + multiplier shift
// WB      | result stable for one cycle, parent writes it back
module acc_bank_mac
  import acc_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             done,
  output logic             idle
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PS_W  = 2 * WIDTH + 1;

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PS_W-1:0]  psum_q, psum_d;
  logic [PS_W-1:0]  addend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      psum_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      psum_q   <= psum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    psum_d   = psum_q;
    addend   = PS_W'(mcand_q) << cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = mcand;
          mplier_d = mplier;
          psum_d   = PS_W'(acc_in);
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mplier_q[0]) psum_d = psum_q + addend;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_WB;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign result   = psum_q[WIDTH-1:0];
  assign overflow = |psum_q[PS_W-1:WIDTH];
  assign done     = (state_q == ST_WB);
  assign idle     = (state_q == ST_IDLE);

endmodule

// File: rtl/acc_bank.sv
// Bank of CHANNELS accumulators with a valid/ready command port, optional saturation,
// shared Z/C/N flags and a multi-cycle MAC engine.
module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SAT_EN   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [2:0]                  op_code,
  input  logic [sel_w(CHANNELS)-1:0]  op_sel,
  input  logic [WIDTH-1:0]            data_a,
  input  logic [WIDTH-1:0]            data_b,
  output logic [CHANNELS*WIDTH-1:0]   acc_out,
  output logic                        flag_z,
  output logic                        flag_c,
  output logic                        flag_n,
  output logic                        done
);

  localparam int              SEL_W  = sel_w(CHANNELS);
  localparam bit              SAT    = (SAT_EN != 0);
  localparam logic [SEL_W:0]  CH_LIM = (SEL_W + 1)'(CHANNELS);

  logic [WIDTH-1:0] acc_q [CHANNELS];
  logic [WIDTH-1:0] acc_d [CHANNELS];
  logic             z_q, z_d, c_q, c_d, n_q, n_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic             accept, sel_ok;
  logic [WIDTH-1:0] cur, res;
  logic [WIDTH:0]   sum, diff;
  logic             c_new, wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic             mac_start, mac_ovf, mac_done, mac_idle;
  logic [WIDTH-1:0] mac_result;

  acc_bank_mac #(.WIDTH(WIDTH)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mac_start),
    .mcand    (data_a),
    .mplier   (data_b),
    .acc_in   (cur),
    .result   (mac_result),
    .overflow (mac_ovf),
    .done     (mac_done),
    .idle     (mac_idle)
  );

  assign op_ready = mac_idle;
  assign accept   = op_valid && op_ready;
  assign sel_ok   = ({1'b0, op_sel} < CH_LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '{default: '0};
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      n_q    <= 1'b0;
      done_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      z_q    <= z_d;
      c_q    <= c_d;
      n_q    <= n_d;
      done_q <= done_d;
      sel_q  <= sel_d;
    end
  end

  always_comb begin
    acc_d     = acc_q;
    z_d       = z_q;
    c_d       = c_q;
    n_d       = n_q;
    sel_d     = sel_q;
    done_d    = mac_done;
    mac_start = 1'b0;
    wr_en     = 1'b0;
    wr_sel    = op_sel;
    res       = '0;
    c_new     = 1'b0;
    cur       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (op_sel == SEL_W'(i)) cur = acc_q[i];
    end
    sum  = {1'b0, cur} + {1'b0, data_a};
    diff = {1'b0, cur} - {1'b0, data_a};

    // MAC writeback owns the write port; no command can be accepted in WB.
    if (mac_done) begin
      wr_en  = 1'b1;
      wr_sel = sel_q;
      c_new  = mac_ovf;
      res    = (SAT && mac_ovf) ? '1 : mac_result;
    end else if (accept && sel_ok) begin
      case (op_code)
        OP_NOP: ;
        OP_LOAD: begin
          wr_en = 1'b1;
          res   = data_a;
        end
        OP_ADD: begin
          wr_en = 1'b1;
          c_new = sum[WIDTH];
          res   = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        end
        OP_SUB: begin
          wr_en = 1'b1;
          c_new = diff[WIDTH];
          res   = (SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
        end
        OP_CLR: wr_en = 1'b1;
        OP_SHL: begin
          wr_en = 1'b1;
          c_new = cur[WIDTH-1];
          res   = cur << 1;
        end
        OP_SHR: begin
          wr_en = 1'b1;
          c_new = cur[0];
          res   = cur >> 1;
        end
        OP_MAC: begin
          mac_start = 1'b1;
          sel_d     = op_sel;
        end
        default: ;
      endcase
    end

    if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_sel == SEL_W'(i)) acc_d[i] = res;
      end
      z_d = (res == '0);
      c_d = c_new;
      n_d = res[WIDTH-1];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign acc_out[g*WIDTH +: WIDTH] = acc_q[g];
  end

  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_n = n_q;
  assign done   = done_q;

endmodule

// File: tb/tb_acc_bank.sv
// Scoreboard bench for acc_bank: a wrapping and a saturating instance share stimulus.
module tb_acc_bank;
  import acc_bank_pkg::*;

  localparam int W  = 8;
  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [1:0]  op_sel = 2'd0;
  logic [7:0]  data_a = 8'h00;
  logic [7:0]  data_b = 8'h00;
  logic [31:0] acc_w, acc_s;
  logic        rdy_w, rdy_s, z_w, c_w, n_w, z_s, c_s, n_s, done_w, done_s;

  always #5 clk = ~clk;

  acc_bank #(.WIDTH(W), .CHANNELS(CH), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(rdy_w),
    .op_code(op_code), .op_sel(op_sel), .data_a(data_a), .data_b(data_b),
    .acc_out(acc_w), .flag_z(z_w), .flag_c(c_w), .flag_n(n_w), .done(done_w)
  );

  acc_bank #(.WIDTH(W), .CHANNELS(CH), .SAT_EN(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(rdy_s),
    .op_code(op_code), .op_sel(op_sel), .data_a(data_a), .data_b(data_b),
    .acc_out(acc_s), .flag_z(z_s), .flag_c(c_s), .flag_n(n_s), .done(done_s)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: index 0 = wrapping instance, 1 = saturating instance.
  logic [7:0]  m_acc [2][CH];
  logic        m_z [2];
  logic        m_c [2];
  logic        m_n [2];
  logic [69:0] exp_q [$];

  function automatic logic [69:0] snap();
    logic [31:0] v0, v1;
    for (int i = 0; i < CH; i++) begin
      v0[i*8 +: 8] = m_acc[0][i];
      v1[i*8 +: 8] = m_acc[1][i];
    end
    return {v0, m_z[0], m_c[0], m_n[0], v1, m_z[1], m_c[1], m_n[1]};
  endfunction

  function automatic logic [69:0] obs();
    return {acc_w, z_w, c_w, n_w, acc_s, z_s, c_s, n_s};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < CH; i++) m_acc[s][i] = 8'h00;
      m_z[s] = 1'b0;
      m_c[s] = 1'b0;
      m_n[s] = 1'b0;
    end
  endtask

  task automatic model_op(input logic [2:0] op, input int sel, input logic [7:0] a, input logic [7:0] b);
    if (op == 3'd0) return;
    for (int s = 0; s < 2; s++) begin
      logic [8:0]  t;
      logic [16:0] p;
      logic [7:0]  r;
      logic        c;
      r = m_acc[s][sel];
      c = 1'b0;
      case (op)
        3'd1: r = a;
        3'd2: begin t = {1'b0, r} + {1'b0, a}; c = t[8]; r = (s != 0 && c) ? 8'hFF : t[7:0]; end
        3'd3: begin t = {1'b0, r} - {1'b0, a}; c = t[8]; r = (s != 0 && c) ? 8'h00 : t[7:0]; end
        3'd4: r = 8'h00;
        3'd5: begin c = r[7]; r = {r[6:0], 1'b0}; end
        3'd6: begin c = r[0]; r = {1'b0, r[7:1]}; end
        default: begin
          p = {9'd0, r} + ({9'd0, a} * {9'd0, b});
          c = |p[16:8];
          r = (s != 0 && c) ? 8'hFF : p[7:0];
        end
      endcase
      m_acc[s][sel] = r;
      m_z[s] = (r == 8'h00);
      m_c[s] = c;
      m_n[s] = r[7];
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
    op_valid = 1'b1;
    op_code  = op;
    op_sel   = sel;
    data_a   = a;
    data_b   = b;
    model_op(op, int'(sel), a, b);
    exp_q.push_back(snap());
  endtask

  task automatic test_reset();
    logic [69:0] e;
    rst_n = 1'b0;
    op_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== snap()) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs(), snap()); end
    checks++;
    if (rdy_w !== 1'b1 || rdy_s !== 1'b1 || done_w !== 1'b0 || done_s !== 1'b0) begin
      failures++; $display("FAIL reset_ready got rdy=%b%b done=%b%b exp rdy=11 done=00", rdy_w, rdy_s, done_w, done_s);
    end
    rst_n = 1'b1;
    drive(OP_LOAD, 2'd2, 8'h55, 8'h00);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL reset_preload got=%h exp=%h", obs(), e); end
    op_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (obs() !== snap()) begin failures++; $display("FAIL reset_midstream got=%h exp=%h", obs(), snap()); end
  endtask

  task automatic test_load_add();
    logic [2:0] ops [3] = '{OP_LOAD, OP_ADD, OP_SUB};
    logic [7:0] av  [3] = '{8'hF0, 8'h20, 8'h10};
    logic [69:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 2'd1, av[i], 8'h00);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL load_add[%0d] got=%h exp=%h", i, obs(), e); end
      if (i == 1) begin
        checks++;
        if ({acc_w[15:8], z_w, c_w, n_w} !== {8'h10, 3'b010}) begin
          failures++; $display("FAIL add_wrap got=%h zcn=%b%b%b exp=10 zcn=010", acc_w[15:8], z_w, c_w, n_w);
        end
      end
    end
    op_valid = 1'b0;
    checks++;
    if ({acc_w[15:8], z_w, c_w} !== {8'h00, 2'b10}) begin
      failures++; $display("FAIL sub_zero got=%h z=%b c=%b exp=00 z=1 c=0", acc_w[15:8], z_w, c_w);
    end
  endtask

  task automatic test_saturation();
    logic [2:0] ops [4] = '{OP_LOAD, OP_ADD, OP_LOAD, OP_SUB};
    logic [7:0] av  [4] = '{8'hF0, 8'h20, 8'h05, 8'h09};
    logic [69:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 2'd2, av[i], 8'h00);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL sat[%0d] got=%h exp=%h", i, obs(), e); end
      if (i == 1) begin
        checks++;
        if ({acc_s[23:16], c_s} !== {8'hFF, 1'b1}) begin
          failures++; $display("FAIL sat_add got=%h c=%b exp=ff c=1", acc_s[23:16], c_s);
        end
      end
    end
    op_valid = 1'b0;
    checks++;
    if ({acc_s[23:16], c_s} !== {8'h00, 1'b1}) begin
      failures++; $display("FAIL sat_sub got=%h c=%b exp=00 c=1", acc_s[23:16], c_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [6] = '{OP_LOAD, OP_SHL, OP_SHR, OP_NOP, OP_SHR, OP_CLR};
    logic [7:0] av  [6] = '{8'h81, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00};
    logic [69:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 2'd0, av[i], 8'h00);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL shift[%0d] got=%h exp=%h", i, obs(), e); end
      checks++;
      if (rdy_w !== 1'b1 || rdy_s !== 1'b1) begin
        failures++; $display("FAIL shift_ready[%0d] got=%b%b exp=11", i, rdy_w, rdy_s);
      end
    end
    op_valid = 1'b0;
  endtask

  // Returns the cycle index (0 = negedge after accept) at which done was seen, -1 on timeout.
  task automatic wait_done(input string tag, output int done_at);
    done_at = -1;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      if (done_w === 1'b1 || done_s === 1'b1) begin
        done_at = j;
        break;
      end
      checks++;
      if (rdy_w !== 1'b0 || rdy_s !== 1'b0) begin
        failures++; $display("FAIL %s_busy_ready[%0d] got=%b%b exp=00", tag, j, rdy_w, rdy_s);
      end
    end
  endtask

  task automatic test_mac();
    logic [69:0] e;
    int at;
    drive(OP_LOAD, 2'd3, 8'h03, 8'h00);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL mac_preload got=%h exp=%h", obs(), e); end
    drive(OP_MAC, 2'd3, 8'h05, 8'h07);
    @(negedge clk);
    op_code = OP_LOAD;
    op_sel  = 2'd0;
    data_a  = 8'hAA;
    wait_done("mac", at);
    op_valid = 1'b0;
    checks++;
    if (at != W + 1) begin failures++; $display("FAIL mac_latency got=%0d exp=%0d", at, W + 1); end
    checks++;
    if ({done_w, done_s, rdy_w, rdy_s} !== 4'b1111) begin
      failures++; $display("FAIL mac_done got done=%b%b rdy=%b%b exp 11 11", done_w, done_s, rdy_w, rdy_s);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL mac_result got=%h exp=<empty scoreboard>", obs());
    end else begin
      e = exp_q.pop_front();
      if (obs() !== e) begin failures++; $display("FAIL mac_result got=%h exp=%h", obs(), e); end
    end
    checks++;
    if (acc_w[31:24] !== 8'h26) begin failures++; $display("FAIL mac_ch3 got=%h exp=26", acc_w[31:24]); end
    @(negedge clk);
    checks++;
    if (done_w !== 1'b0 || done_s !== 1'b0) begin
      failures++; $display("FAIL mac_pulse got=%b%b exp=00", done_w, done_s);
    end
  endtask

  task automatic test_mac_overflow_abort();
    logic [69:0] e;
    int at;
    drive(OP_LOAD, 2'd3, 8'h10, 8'h00);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL ovf_preload got=%h exp=%h", obs(), e); end
    drive(OP_MAC, 2'd3, 8'h10, 8'h10);
    @(negedge clk);
    op_valid = 1'b0;
    wait_done("ovf", at);
    checks++;
    if (at < 0 || exp_q.size() == 0) begin
      failures++; $display("FAIL ovf_result got timeout/empty at=%0d exp=done", at);
    end else begin
      e = exp_q.pop_front();
      if (obs() !== e) begin failures++; $display("FAIL ovf_result got=%h exp=%h", obs(), e); end
    end
    checks++;
    if ({acc_w[31:24], c_w, acc_s[31:24], c_s} !== {8'h10, 1'b1, 8'hFF, 1'b1}) begin
      failures++; $display("FAIL ovf_values got w=%h c=%b s=%h c=%b exp w=10 c=1 s=ff c=1", acc_w[31:24], c_w, acc_s[31:24], c_s);
    end
    @(negedge clk);
    drive(OP_LOAD, 2'd3, 8'h10, 8'h00);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL abort_preload got=%h exp=%h", obs(), e); end
    drive(OP_MAC, 2'd3, 8'h10, 8'h10);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_reset();
    checks++;
    if (obs() !== snap() || rdy_w !== 1'b1 || rdy_s !== 1'b1) begin
      failures++; $display("FAIL abort_reset got=%h rdy=%b%b exp=%h rdy=11", obs(), rdy_w, rdy_s, snap());
    end
    at = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done_w === 1'b1 || done_s === 1'b1) at++;
    end
    checks++;
    if (at != 0) begin failures++; $display("FAIL abort_no_done got=%0d pulses exp=0", at); end
    checks++;
    if (obs() !== snap()) begin failures++; $display("FAIL abort_hold got=%h exp=%h", obs(), snap()); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_saturation();
    test_back_to_back();
    test_mac();
    test_mac_overflow_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
